// File: rtl/dct2d_row_col_ctrl.sv
// Row/column sequencer that time-shares one 1D 8-point DCT core
// across both passes of an 8x8 2D DCT; drives selects/addresses only.
module dct2d_row_col_ctrl #(
    parameter int DCT_LAT = 1,
    parameter int N       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dct_sel,
    output logic       dct_in_valid,
    output logic       tbuf_we,
    output logic [2:0] tbuf_waddr,
    output logic [2:0] tbuf_raddr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       busy
);

    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        ROW_DRAIN,
        COL_ISSUE,
        COL_WAIT
    } state_t;

    state_t state;

    logic [2:0] row_cnt;
    logic [2:0] col_cnt;
    logic [3:0] wait_cnt;
    logic       accept;

    logic [DCT_LAT-1:0] dl_vld;
    logic [2:0]         dl_idx [DCT_LAT];

    assign in_ready     = (state == IDLE) || (state == ROW);
    assign accept       = in_valid && in_ready;
    assign dct_sel      = (state == COL_ISSUE) || (state == COL_WAIT);
    assign dct_in_valid = accept || (state == COL_ISSUE);
    assign tbuf_we      = dl_vld[DCT_LAT-1];
    assign tbuf_waddr   = dl_idx[DCT_LAT-1];
    assign tbuf_raddr   = col_cnt;
    assign out_valid    = (state == COL_WAIT) && (wait_cnt == 4'd0);
    assign out_idx      = col_cnt;
    assign out_last     = out_valid && (col_cnt == LAST);
    assign busy         = (state != IDLE);

    // Row index travels alongside the core pipeline so each result lands
    // in the buffer row it came from, gaps included.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < DCT_LAT; i++) begin
                dl_idx[i] <= '0;
            end
        end else begin
            dl_vld[0] <= accept;
            dl_idx[0] <= row_cnt;
            for (int i = 1; i < DCT_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            col_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE, ROW: begin
                    if (accept) begin
                        if (row_cnt == LAST) begin
                            row_cnt <= '0;
                            state   <= ROW_DRAIN;
                        end else begin
                            row_cnt <= row_cnt + 3'd1;
                            state   <= ROW;
                        end
                    end
                end
                ROW_DRAIN: begin
                    if (tbuf_we && (tbuf_waddr == LAST)) begin
                        state <= COL_ISSUE;
                    end
                end
                COL_ISSUE: begin
                    wait_cnt <= 4'(DCT_LAT - 1);
                    state    <= COL_WAIT;
                end
                COL_WAIT: begin
                    // One column in flight: the core output must hold until taken.
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (out_ready) begin
                        if (col_cnt == LAST) begin
                            col_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            col_cnt <= col_cnt + 3'd1;
                            state   <= COL_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
